// File: rtl/ro_sampler_ctrl.sv
// Ring-oscillator TRNG sampler: warm-up, XOR decimation into words, valid/ready output.
// Optional repetition-count health test enabled by defining HEALTH_TEST_EN.
module ro_sampler_ctrl #(
    parameter int unsigned NUM_RO    = 4,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned WARMUP    = 64,
    parameter int unsigned DECIM     = 8,
    parameter int unsigned REP_LIMIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [NUM_RO-1:0] ro_halt,
    input  logic [NUM_RO-1:0] ro_signal,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int unsigned WU_W = $clog2(WARMUP + 1);
    localparam int unsigned DC_W = $clog2(DECIM + 1);
    localparam int unsigned BC_W = $clog2(WORD_W + 1);

    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECIM - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_RO-1:0] sync_q;
    logic [WU_W-1:0]   warm_q, warm_d;
    logic [DC_W-1:0]   dec_q, dec_d;
    logic [BC_W-1:0]   bits_q, bits_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              raw_bit;
    logic              bit_tick;

`ifdef HEALTH_TEST_EN
    localparam int unsigned RC_W = $clog2(REP_LIMIT + 1);
    localparam logic [RC_W-1:0] RC_LIMIT = RC_W'(REP_LIMIT);
    logic [RC_W-1:0] rep_q, rep_d;
    logic            last_q, last_d;
`endif

    assign raw_bit  = ^sync_q;
    assign bit_tick = (state_q == S_COLLECT) && !stop && (dec_q == DC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            warm_q  <= '0;
            dec_q   <= '0;
            bits_q  <= '0;
            data_q  <= '0;
`ifdef HEALTH_TEST_EN
            rep_q   <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= ro_signal;
            warm_q  <= warm_d;
            dec_q   <= dec_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
`ifdef HEALTH_TEST_EN
            rep_q   <= rep_d;
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        dec_d   = dec_q;
        bits_d  = bits_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                warm_d = '0;
                dec_d  = '0;
                bits_d = '0;
                if (start && !stop) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (warm_q == WU_LAST) begin
                    state_d = S_COLLECT;
                    dec_d   = '0;
                    bits_d  = '0;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (bit_tick) begin
                    dec_d  = '0;
                    data_d = {data_q[WORD_W-2:0], raw_bit};
                    bits_d = bits_q + 1'b1;
                    if (bits_q == BC_LAST) state_d = S_HOLD;
                end else begin
                    dec_d = dec_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (ready) begin
                    state_d = S_COLLECT;
                    dec_d   = '0;
                    bits_d  = '0;
                end
            end
            S_FAIL: ;
            default: state_d = S_IDLE;
        endcase

`ifdef HEALTH_TEST_EN
        rep_d  = rep_q;
        last_d = last_q;
        if (state_q == S_IDLE) rep_d = '0;
        // A failing bit overrides the HOLD transition, so a completing word is dropped.
        if (bit_tick) begin
            if ((rep_q != '0) && (raw_bit == last_q)) rep_d = rep_q + 1'b1;
            else                                      rep_d = RC_W'(1);
            last_d = raw_bit;
            if (rep_d == RC_LIMIT) state_d = S_FAIL;
        end
`endif
    end

    always_comb begin
        ro_halt = ((state_q == S_IDLE) || (state_q == S_FAIL)) ? '1 : '0;
        valid   = (state_q == S_HOLD);
        busy    = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_HOLD);
        data    = data_q;
`ifdef HEALTH_TEST_EN
        health_fail = (state_q == S_FAIL);
`else
        health_fail = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ro_sampler_ctrl.sv
// Directed bench for ro_sampler_ctrl with WARMUP=4, DECIM=2, WORD_W=8, REP_LIMIT=4.
// Health-test expectations follow HEALTH_TEST_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_ro_sampler_ctrl;
    localparam int unsigned NRO = 4;
    localparam int unsigned WW  = 8;
    localparam int NV = 16;

    logic           clock;
    logic           reset;
    logic           start;
    logic           stop;
    logic           ready;
    logic [NRO-1:0] ro_signal;
    logic [NRO-1:0] ro_halt;
    logic [WW-1:0]  data;
    logic           valid;
    logic           busy;
    logic           health_fail;

    int n_vec;
    int n_bad;
    int ec;
    int e0;
    bit pat_const;

    typedef struct {
        logic      st;
        logic      sp;
        logic      rd;
        int        n;
        logic      v;
        logic      b;
        logic      h;
        logic      cd;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [NV];

    ro_sampler_ctrl #(
        .NUM_RO(NRO), .WORD_W(WW), .WARMUP(4), .DECIM(2), .REP_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .ro_halt(ro_halt), .ro_signal(ro_signal), .data(data),
        .valid(valid), .ready(ready), .busy(busy), .health_fail(health_fail)
    );

    always #5 clock = ~clock;

    // Bit shifted at relative edge e is ((e/2)&1); ro_signal is sampled two edges earlier.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            ec++;
            #1;
            if (pat_const) ro_signal = 4'b0111;
            else if ((((ec - e0) + 2) / 2) % 2 != 0) ro_signal = 4'b0111;
            else ro_signal = 4'b0101;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic v, input logic b, input logic h, input logic hf);
        chk({nm, ".valid"}, 32'(valid), 32'(v));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".halt"}, 32'(ro_halt), h ? 32'hF : 32'h0);
        chk({nm, ".hfail"}, 32'(health_fail), 32'(hf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // {start, stop, ready, edges, valid, busy, halt, check_data, data}; edges relative to start edge 0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00}; // edge 0
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; // edge 3
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; // edge 4
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55}; // edge 19, 7 bits in
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA}; // edge 20
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'hAA}; // edge 25
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b1, 8'hAA}; // edge 26 handshake
        tbl[11] = '{1'b0, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2A}; // edge 41
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 8'h55}; // edge 42
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b1, 8'h55}; // edge 45
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b1, 8'h55}; // edge 46 stop beats ready
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1'b1, 8'h55}; // edge 48

        n_vec = 0; n_bad = 0; ec = 0; e0 = 1000; pat_const = 1'b0;
        clock = 1'b0; reset = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0;
        ro_signal = '0;

        #2;
        chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.data", 32'(data), 32'h0);
        #10;
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            step(1);
            chk_ctl("idle", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("idle.data", 32'(data), 32'h0);
        end

        e0 = ec + 1;
        for (int i = 0; i < NV; i++) begin
            start = tbl[i].st;
            stop  = tbl[i].sp;
            ready = tbl[i].rd;
            step(tbl[i].n);
            chk_ctl($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].b, tbl[i].h, 1'b0);
            if (tbl[i].cd) chk($sformatf("tbl[%0d].data", i), 32'(data), 32'(tbl[i].d));
        end
        start = 1'b0; stop = 1'b0; ready = 1'b0;

        start = 1'b1; stop = 1'b1;
        step(1);
        chk_ctl("startstop1", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_ctl("startstop2", 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; stop = 1'b0;
        step(1);

        e0 = ec + 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        chk_ctl("stop.e10", 1'b0, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step(1);
        chk_ctl("stop.e11", 1'b0, 1'b0, 1'b1, 1'b0);
        stop = 1'b0;
        step(15);
        chk_ctl("stop.idle", 1'b0, 1'b0, 1'b1, 1'b0);

        e0 = ec + 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk_ctl("rerun.e0", 1'b0, 1'b1, 1'b0, 1'b0);
        step(19);
        chk_ctl("rerun.e19", 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_ctl("rerun.e20", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rerun.data", 32'(data), 32'hAA);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk_ctl("rerun.stop", 1'b0, 1'b0, 1'b1, 1'b0);

        pat_const = 1'b1;
        step(2);
        e0 = ec + 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(11);
        chk_ctl("health.e11", 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
`ifdef HEALTH_TEST_EN
        chk_ctl("health.e12", 1'b0, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        step(3);
        chk_ctl("health.sticky", 1'b0, 1'b0, 1'b1, 1'b1);
        stop = 1'b1;
        step(2);
        chk_ctl("health.stop", 1'b0, 1'b0, 1'b1, 1'b1);
        start = 1'b0; stop = 1'b0;
`else
        chk_ctl("ones.e12", 1'b0, 1'b1, 1'b0, 1'b0);
        step(8);
        chk_ctl("ones.e20", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ones.data", 32'(data), 32'hFF);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(16);
        chk_ctl("ones.e37", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ones.data2", 32'(data), 32'hFF);
`endif
        reset = 1'b1;
        #2;
        chk_ctl("rst2", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst2.data", 32'(data), 32'h0);
        step(2);
        reset = 1'b0;
        pat_const = 1'b0;
        step(2);
        chk_ctl("rst2.idle", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
